// File: rtl/demux2_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer.
//   SEL_A / SEL_B          : meaning of the per-word route bit
//   SLOT_EMPTY / SLOT_FULL : one-entry slot state encoding
//   DEF_CNT_W              : default width of the optional delivery counters
package demux2_pkg;

   localparam logic [0:0] SEL_A      = 1'b0;
   localparam logic [0:0] SEL_B      = 1'b1;

   localparam logic [0:0] SLOT_EMPTY = 1'b0;
   localparam logic [0:0] SLOT_FULL  = 1'b1;

   localparam int         DEF_CNT_W  = 16;

endpackage

// File: rtl/demux2_slot.sv
// One-entry register slice with a valid/ready output handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : write i_data into the slot at this edge
//   i_data     : word to store
//   i_ready    : consumer takes the held word this cycle
//   o_valid    : slot holds a word
//   o_data     : held word (stable while stalled)
//
//   state      | meaning
//   SLOT_EMPTY | nothing held, o_valid=0
//   SLOT_FULL  | a word is held, o_valid=1
module demux2_slot
   import demux2_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SLOT_EMPTY;
         r_data  <= '0;
      end else begin
         // A load wins over a drain: a same-edge take-and-refill stays FULL.
         if (i_load) begin
            r_state <= SLOT_FULL;
            r_data  <= i_data;
         end else if (i_ready && (r_state == SLOT_FULL)) begin
            r_state <= SLOT_EMPTY;
         end
      end
   end

   assign o_valid = (r_state == SLOT_FULL);
   assign o_data  = r_data;

endmodule

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer. Each input word is steered to
// output A or B by in_sel and held in that output's one-entry slot.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready/in_sel/in_data : producer side
//   a_valid/a_ready/a_data      : consumer A
//   b_valid/b_ready/b_data      : consumer B
//   a_count/b_count             : delivered-word counters, saturating
//                                 (only when DEMUX2_STATS_EN is defined)
module demux2_stream
   import demux2_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] b_data
`ifdef DEMUX2_STATS_EN
   ,
   output logic [CNT_W-1:0] a_count,
   output logic [CNT_W-1:0] b_count
`endif
);

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("demux2_stream: CNT_W must be at least 1");
   end

   logic w_a_valid;
   logic w_b_valid;
   logic w_in_ready;
   logic w_accept;
   logic w_load_a;
   logic w_load_b;

   // Ready depends only on the selected slot, never on in_valid.
   assign w_in_ready = (in_sel == SEL_B) ? (!w_b_valid || b_ready)
                                         : (!w_a_valid || a_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_load_a   = w_accept && (in_sel == SEL_A);
   assign w_load_b   = w_accept && (in_sel == SEL_B);

   demux2_slot #(.WIDTH(WIDTH)) u_slot_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load_a),
      .i_data  (in_data),
      .i_ready (a_ready),
      .o_valid (w_a_valid),
      .o_data  (a_data)
   );

   demux2_slot #(.WIDTH(WIDTH)) u_slot_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load_b),
      .i_data  (in_data),
      .i_ready (b_ready),
      .o_valid (w_b_valid),
      .o_data  (b_data)
   );

   assign in_ready = w_in_ready;
   assign a_valid  = w_a_valid;
   assign b_valid  = w_b_valid;

`ifdef DEMUX2_STATS_EN
   logic [CNT_W-1:0] r_a_count;
   logic [CNT_W-1:0] r_b_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_count <= '0;
         r_b_count <= '0;
      end else begin
         if (w_a_valid && a_ready && (r_a_count != {CNT_W{1'b1}}))
            r_a_count <= r_a_count + CNT_W'(1);
         if (w_b_valid && b_ready && (r_b_count != {CNT_W{1'b1}}))
            r_b_count <= r_b_count + CNT_W'(1);
      end
   end

   assign a_count = r_a_count;
   assign b_count = r_b_count;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
module tb_demux2_stream;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic             in_sel;
   logic [WIDTH-1:0] in_data;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] a_data;
   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] b_data;
`ifdef DEMUX2_STATS_EN
   logic [CNT_W-1:0] a_count;
   logic [CNT_W-1:0] b_count;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   logic [WIDTH-1:0] exp_a[$];
   logic [WIDTH-1:0] exp_b[$];
   int               mdl_cnt_a = 0;
   int               mdl_cnt_b = 0;

   demux2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sel   (in_sel),
      .in_data  (in_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data)
`ifdef DEMUX2_STATS_EN
      ,
      .a_count  (a_count),
      .b_count  (b_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check against the model, predict, advance.
   task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic ar, input logic br);
      logic rdy;
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      a_ready  = ar;
      b_ready  = br;
      #1;
      rdy = s ? ((exp_b.size() == 0) || br) : ((exp_a.size() == 0) || ar);
      check("a_valid", 32'(a_valid), 32'(exp_a.size() != 0));
      check("b_valid", 32'(b_valid), 32'(exp_b.size() != 0));
      if (exp_a.size() != 0) check("a_data", 32'(a_data), 32'(exp_a[0]));
      if (exp_b.size() != 0) check("b_data", 32'(b_data), 32'(exp_b[0]));
      check("in_ready", 32'(in_ready), 32'(rdy));
`ifdef DEMUX2_STATS_EN
      check("a_count", 32'(a_count), 32'(mdl_cnt_a));
      check("b_count", 32'(b_count), 32'(mdl_cnt_b));
`endif
      if (ar && exp_a.size() != 0) begin
         void'(exp_a.pop_front());
         if (mdl_cnt_a < CNT_MAX) mdl_cnt_a++;
      end
      if (br && exp_b.size() != 0) begin
         void'(exp_b.pop_front());
         if (mdl_cnt_b < CNT_MAX) mdl_cnt_b++;
      end
      if (v && rdy) begin
         if (s) exp_b.push_back(d);
         else   exp_a.push_back(d);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sel   = 1'b0;
      in_data  = '0;
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_a_valid", 32'(a_valid), 32'd0);
      check("rst_b_valid", 32'(b_valid), 32'd0);
      check("rst_a_data",  32'(a_data),  32'd0);
      check("rst_b_data",  32'(b_data),  32'd0);
`ifdef DEMUX2_STATS_EN
      check("rst_a_count", 32'(a_count), 32'd0);
      check("rst_b_count", 32'(b_count), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single word to A, one-cycle latency, B untouched
      cycle(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
      #1;
      check("t1_a_valid", 32'(a_valid), 32'd1);
      check("t1_a_data",  32'(a_data),  32'hA5);
      check("t1_b_valid", 32'(b_valid), 32'd0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

      // 2: A stalls full; A-bound word refused, B-bound word still accepted
      cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
      #1;
      check("t2_a_data", 32'(a_data), 32'h11);
      check("t2_b_data", 32'(b_data), 32'h22);

      // 3: drain and refill A on the same edge
      cycle(1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
      #1;
      check("t3_a_valid", 32'(a_valid), 32'd1);
      check("t3_a_data",  32'(a_data),  32'h33);
      check("t3_b_data",  32'(b_data),  32'h22);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

      // 4: full-rate alternating stream, both consumers always ready
      for (int i = 0; i < 16; i++) begin
         logic [7:0] w;
         w = 8'(i);
         cycle(1'b1, w[0], w, 1'b1, 1'b1);
      end
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
      check("t4_a_drained", 32'(exp_a.size()), 32'd0);
      check("t4_b_drained", 32'(exp_b.size()), 32'd0);

      // 5: asynchronous reset with both slots full
      cycle(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
      #1;
      check("t5_pre_a_valid", 32'(a_valid), 32'd1);
      check("t5_pre_b_valid", 32'(b_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_a_valid", 32'(a_valid), 32'd0);
      check("t5_b_valid", 32'(b_valid), 32'd0);
      check("t5_a_data",  32'(a_data),  32'd0);
      check("t5_b_data",  32'(b_data),  32'd0);
      exp_a.delete();
      exp_b.delete();
      mdl_cnt_a = 0;
      mdl_cnt_b = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
      #1;
      check("t5_post_a_data", 32'(a_data), 32'h77);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

`ifdef DEMUX2_STATS_EN
      // 6: counter saturation on A, B untouched
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'(i + 8'h80), 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      check("t6_a_count", 32'(a_count), 32'(CNT_MAX));
      check("t6_b_count", 32'(b_count), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
